// File: rtl/clint_arbiter.sv
// Round-robin arbiter sharing one CLINT register port among NREQ pulse-driven requesters.
// Each port owns a one-entry request slot; a watchdog answers unmapped addresses with an error.
module clint_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_instr,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_wstrb,
    output logic [NREQ*32-1:0]   req_rdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_error,
    output logic                 clint_valid,
    output logic                 clint_instr,
    output logic [31:0]          clint_addr,
    output logic [31:0]          clint_wdata,
    output logic [3:0]           clint_wstrb,
    input  logic [31:0]          clint_rdata,
    input  logic                 clint_ready
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] pending;

    logic [NREQ-1:0] slot_instr;
    logic [31:0]     slot_addr  [NREQ];
    logic [31:0]     slot_wdata [NREQ];
    logic [3:0]      slot_wstrb [NREQ];

    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic            done_ok;
    logic            done_to;
    logic [NREQ-1:0] clear_mask;
    logic [NREQ-1:0] capture;

    // First pending port after last_grant, wrapping modulo NREQ.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(idx);
            end
        end
    end

    assign done_ok = (state == BUSY) && clint_ready;
    assign done_to = (state == BUSY) && !clint_ready &&
                     (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    // A completing port frees its slot in the same cycle, so a coincident new pulse is accepted.
    always_comb begin
        clear_mask = '0;
        if (done_ok || done_to) clear_mask[grant] = 1'b1;
    end

    assign capture = req_valid & (~pending | clear_mask);

    // NOTE: slot storage has no reset; nothing reads a slot unless its pending bit is set.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NREQ; p++) begin
            if (capture[p]) begin
                slot_instr[p] <= req_instr[p];
                slot_addr[p]  <= req_addr[32*p +: 32];
                slot_wdata[p] <= req_wdata[32*p +: 32];
                slot_wstrb[p] <= req_wstrb[4*p +: 4];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GW'(NREQ - 1);
            timer       <= '0;
            pending     <= '0;
            req_rdata   <= '0;
            req_ready   <= '0;
            req_error   <= '0;
            clint_valid <= 1'b0;
            clint_instr <= 1'b0;
            clint_addr  <= '0;
            clint_wdata <= '0;
            clint_wstrb <= '0;
        end else begin
            clint_valid <= 1'b0;
            req_ready   <= '0;
            req_error   <= '0;
            req_rdata   <= '0;
            pending     <= (pending & ~clear_mask) | capture;

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        clint_valid <= 1'b1;
                        clint_instr <= slot_instr[sel_idx];
                        clint_addr  <= slot_addr[sel_idx];
                        clint_wdata <= slot_wdata[sel_idx];
                        clint_wstrb <= slot_wstrb[sel_idx];
                        grant       <= sel_idx;
                        timer       <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_ok || done_to) begin
                        req_ready[grant] <= 1'b1;
                        req_error[grant] <= done_to;
                        if (done_ok) req_rdata[32*int'(grant) +: 32] <= clint_rdata;
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed bench for clint_arbiter: vector table of single transactions plus
// hand sequences for round-robin order, timeout, duplicate pulses and mid-transaction reset.
module tb_clint_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_instr;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0] req_wstrb;
    logic [NREQ*32-1:0] req_rdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_error;
    logic              clint_valid;
    logic              clint_instr;
    logic [31:0]       clint_addr;
    logic [31:0]       clint_wdata;
    logic [3:0]        clint_wstrb;
    logic [31:0]       clint_rdata;
    logic              clint_ready;

    int passed = 0;
    int total  = 0;

    clint_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
        .req_ready(req_ready), .req_error(req_error),
        .clint_valid(clint_valid), .clint_instr(clint_instr), .clint_addr(clint_addr),
        .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb),
        .clint_rdata(clint_rdata), .clint_ready(clint_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] crdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        req_instr[p]          = instr;
        req_addr[32*p +: 32]  = addr;
        req_wdata[32*p +: 32] = wdata;
        req_wstrb[4*p +: 4]   = wstrb;
    endtask

    task automatic pulse(input logic [NREQ-1:0] mask);
        req_valid = mask;
        step();
        req_valid = '0;
    endtask

    // CLINT answers after `delay` idle BUSY cycles; returns right after the response edge.
    task automatic respond(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) step();
        clint_ready = 1'b1;
        clint_rdata = data;
        step();
        clint_ready = 1'b0;
        clint_rdata = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " clint_valid"}, 64'(clint_valid), 64'd0);
        check({name, " clint_fields"}, {23'd0, clint_instr, clint_addr, clint_wdata[3:0], clint_wstrb}, 64'd0);
        check({name, " req_out"}, {58'd0, req_ready, req_error, 2'd0} | 64'(req_rdata != 0), 64'd0);
    endtask

    int ready_pulses;
    int valid_pulses;

    initial begin
        rst = 1'b0;
        req_valid = '0; req_instr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        clint_rdata = '0; clint_ready = 1'b0;

        vecs[0] = '{1, 1'b0, 32'd49144,      32'h0,         4'h0, 32'h0000_1234, 32'h0000_1234};
        vecs[1] = '{0, 1'b0, 32'd16384,      32'h10,        4'hF, 32'h0,         32'h0};
        vecs[2] = '{0, 1'b1, 32'h0200_BFF8,  32'h0,         4'h0, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{1, 1'b0, 32'h0200_4000,  32'hA5A5_5A5A, 4'h3, 32'h0000_0077, 32'h0000_0077};

        step(); step();
        check_all_zero("reset");
        rst = 1'b1;

        // Round-robin: both at once after reset -> port0 then port1.
        set_port(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        pulse(2'b11);
        step();
        check("rr0 first valid", 64'(clint_valid), 64'd1);
        check("rr0 first addr", 64'(clint_addr), 64'h100);
        respond(1, 32'h11);
        check("rr0 first ready", 64'(req_ready), 64'b01);
        step();
        check("rr0 second valid", 64'(clint_valid), 64'd1);
        check("rr0 second addr", 64'(clint_addr), 64'h200);
        respond(1, 32'h22);
        check("rr0 second ready", 64'(req_ready), 64'b10);
        check("rr0 second rdata", 64'(req_rdata), {32'h22, 32'h0});
        step();

        // Table of single uncontended transactions, CLINT answering in one cycle.
        foreach (vecs[k]) begin
            set_port(vecs[k].port, vecs[k].instr, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb);
            pulse(2'b01 << vecs[k].port);
            check($sformatf("vec%0d no early valid", k), 64'(clint_valid), 64'd0);
            step();
            check($sformatf("vec%0d valid", k), 64'(clint_valid), 64'd1);
            check($sformatf("vec%0d fields", k),
                  {27'd0, clint_instr, clint_wstrb, clint_addr},
                  {27'd0, vecs[k].instr, vecs[k].wstrb, vecs[k].addr});
            check($sformatf("vec%0d wdata", k), 64'(clint_wdata), 64'(vecs[k].wdata));
            step();
            check($sformatf("vec%0d pulse ends", k), {62'd0, clint_valid, |req_ready}, 64'd0);
            check($sformatf("vec%0d held addr", k), 64'(clint_addr), 64'(vecs[k].addr));
            clint_ready = 1'b1;
            clint_rdata = vecs[k].crdata;
            step();
            clint_ready = 1'b0;
            clint_rdata = '0;
            check($sformatf("vec%0d ready", k), 64'(req_ready), 64'(2'b01 << vecs[k].port));
            check($sformatf("vec%0d error", k), 64'(req_error), 64'd0);
            check($sformatf("vec%0d rdata", k), 64'(req_rdata),
                  64'(vecs[k].exp_rdata) << (32 * vecs[k].port));
            step();
            check($sformatf("vec%0d ready drops", k), 64'(req_ready), 64'd0);
        end

        // Last served was port1 -> both pulse -> port0 first.
        set_port(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        pulse(2'b11);
        step();
        check("rr1 first addr", 64'(clint_addr), 64'h300);
        respond(1, 32'h0);
        step();
        check("rr1 second addr", 64'(clint_addr), 64'h400);
        respond(1, 32'h0);
        step();

        // Port0 alone, then both -> port1 first.
        pulse(2'b01);
        step();
        respond(1, 32'h0);
        step();
        pulse(2'b11);
        step();
        check("rr2 first addr", 64'(clint_addr), 64'h400);
        respond(1, 32'h0);
        step();
        check("rr2 second addr", 64'(clint_addr), 64'h300);
        respond(1, 32'h0);
        step();

        // Timeout: no clint_ready -> error response 16 cycles after BUSY entry.
        set_port(1, 1'b0, 32'h0000_8000, 32'h0, 4'h0);
        pulse(2'b10);
        step();
        check("to valid", 64'(clint_valid), 64'd1);
        ready_pulses = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            if (req_ready != 0) ready_pulses++;
        end
        check("to no early ready", 64'(ready_pulses), 64'd0);
        step();
        check("to ready", 64'(req_ready), 64'b10);
        check("to error", 64'(req_error), 64'b10);
        check("to rdata", 64'(req_rdata), 64'd0);
        clint_ready = 1'b1;
        clint_rdata = 32'hBAD;
        step();
        clint_ready = 1'b0;
        clint_rdata = '0;
        ready_pulses = 0;
        valid_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (req_ready != 0) ready_pulses++;
            if (clint_valid) valid_pulses++;
            step();
        end
        check("stray ready ignored", 64'(ready_pulses), 64'd0);
        check("stray no grant", 64'(valid_pulses), 64'd0);

        // Duplicate pulses while pending -> one response, first request's data.
        set_port(0, 1'b0, 32'h0000_0A00, 32'h0, 4'h0);
        pulse(2'b01);
        step();
        check("dup first addr", 64'(clint_addr), 64'hA00);
        set_port(0, 1'b0, 32'h0000_0B00, 32'h0, 4'h0);
        pulse(2'b01);
        set_port(0, 1'b0, 32'h0000_0C00, 32'h0, 4'h0);
        pulse(2'b01);
        step();
        check("dup held addr", 64'(clint_addr), 64'hA00);
        ready_pulses = 0;
        valid_pulses = 0;
        clint_ready = 1'b1;
        clint_rdata = 32'h5555;
        step();
        clint_ready = 1'b0;
        clint_rdata = '0;
        check("dup rdata", 64'(req_rdata), 64'h5555);
        for (int i = 0; i < 8; i++) begin
            if (req_ready[0]) ready_pulses++;
            if (clint_valid) valid_pulses++;
            step();
        end
        check("dup one ready", 64'(ready_pulses), 64'd1);
        check("dup no regrant", 64'(valid_pulses), 64'd0);

        // New pulse on the completing port is captured and served next.
        set_port(0, 1'b0, 32'h0000_0D00, 32'h0, 4'h0);
        pulse(2'b01);
        step();
        set_port(0, 1'b0, 32'h0000_0E00, 32'h0, 4'h0);
        req_valid = 2'b01;
        respond(0, 32'h1);
        req_valid = '0;
        check("coinc ready", 64'(req_ready), 64'b01);
        step();
        check("coinc regrant valid", 64'(clint_valid), 64'd1);
        check("coinc regrant addr", 64'(clint_addr), 64'hE00);
        respond(1, 32'h2);
        check("coinc second ready", 64'(req_ready), 64'b01);
        step();

        // Reset while BUSY drops the transaction and any pending request.
        set_port(0, 1'b0, 32'h0000_0F00, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0000_0F40, 32'h0, 4'h0);
        pulse(2'b11);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_all_zero("midreset");
        clint_ready = 1'b1;
        clint_rdata = 32'h9;
        step();
        clint_ready = 1'b0;
        clint_rdata = '0;
        ready_pulses = 0;
        valid_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready != 0) ready_pulses++;
            if (clint_valid) valid_pulses++;
            step();
        end
        check("midreset no ready", 64'(ready_pulses), 64'd0);
        check("midreset pending dropped", 64'(valid_pulses), 64'd0);
        set_port(1, 1'b0, 32'h0000_0F80, 32'h0, 4'h0);
        pulse(2'b10);
        step();
        check("post reset addr", 64'(clint_addr), 64'hF80);
        respond(1, 32'h77);
        check("post reset ready", 64'(req_ready), 64'b10);
        check("post reset rdata", 64'(req_rdata), {32'h77, 32'h0});
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
